// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states
// and small elaboration helpers.
package mdu_iter_pkg;

  localparam logic [3:0] MDU_MULT  = 4'h0;
  localparam logic [3:0] MDU_MULTU = 4'h1;
  localparam logic [3:0] MDU_DIV   = 4'h2;
  localparam logic [3:0] MDU_DIVU  = 4'h3;
  localparam logic [3:0] MDU_MADD  = 4'h4;
  localparam logic [3:0] MDU_MADDU = 4'h5;
  localparam logic [3:0] MDU_MSUB  = 4'h6;
  localparam logic [3:0] MDU_MSUBU = 4'h7;
  localparam logic [3:0] MDU_MTHI  = 4'h8;
  localparam logic [3:0] MDU_MTLO  = 4'h9;
  localparam logic [3:0] MDU_NOP   = 4'hF;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } mdu_state_e;

  // All multicycle ops live in the lower half of the encoding space.
  function automatic logic is_multicycle(input logic [3:0] op);
    return ~op[3];
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// E-stage issue/result bundle between the pipeline and the multiply/divide unit.
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_iter_calc.sv
// Combinational next-{hi,lo} for every multicycle op, from latched operands and the
// current HI/LO; includes divide-by-zero and signed-overflow handling.
module mdu_iter_calc
  import mdu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic             is_signed;
  logic [W2-1:0]    a_ext;
  logic [W2-1:0]    b_ext;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    acc;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  assign is_signed = (op == MDU_MULT) || (op == MDU_MADD) ||
                     (op == MDU_MSUB) || (op == MDU_DIV);

  // Extending to 2*WIDTH before multiplying gives the signed or unsigned product
  // directly, modulo 2^(2*WIDTH).
  assign a_ext = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;
  assign acc   = {hi, lo};

  // Sign-magnitude division. The most-negative / -1 case needs no special path: its
  // magnitude quotient 2^(WIDTH-1) negates back to itself and the remainder is zero.
  assign a_neg  = is_signed & a[WIDTH-1];
  assign b_neg  = is_signed & b[WIDTH-1];
  assign a_mag  = a_neg ? (~a + 1'b1) : a;
  assign b_mag  = b_neg ? (~b + 1'b1) : b;
  assign b_safe = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 1'b1) : r_mag;

  always_comb begin
    hi_next = hi;
    lo_next = lo;
    case (op)
      MDU_MULT, MDU_MULTU: {hi_next, lo_next} = prod;
      MDU_MADD, MDU_MADDU: {hi_next, lo_next} = acc + prod;
      MDU_MSUB, MDU_MSUBU: {hi_next, lo_next} = acc - prod;
      MDU_DIV, MDU_DIVU: begin
        if (b == '0) begin
          hi_next = a;
          lo_next = '1;
        end else begin
          hi_next = rem;
          lo_next = quot;
        end
      end
      default: begin
        hi_next = hi;
        lo_next = lo;
      end
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// Multicycle multiply/divide unit holding HI/LO: latches operands on accept, counts the
// configured latency, then commits the combinational result and pulses done.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);

  localparam int unsigned MaxCycles = max_u(MULT_CYCLES, DIV_CYCLES);
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic [CntW-1:0]  latency;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  assign accept  = bus.start & ~bus.cancel & ~busy_q;
  assign latency = is_div(bus.op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);

  mdu_iter_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .hi      (hi_q),
    .lo      (lo_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= MDU_NOP;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept && is_multicycle(bus.op)) begin
            op_q    <= bus.op;
            a_q     <= bus.a;
            b_q     <= bus.b;
            cnt_q   <= latency;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else if (accept && (bus.op == MDU_MTHI)) begin
            hi_q <= bus.a;
          end else if (accept && (bus.op == MDU_MTLO)) begin
            lo_q <= bus.a;
          end
        end
        StRun: begin
          // Nothing else can write HI/LO while busy, so madd/msub see a stable base here.
          if (cnt_q == CntW'(1)) begin
            hi_q    <= hi_next;
            lo_q    <= lo_next;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: latency, results, divide corners,
// accumulate, cancel, start-while-busy and reset-mid-operation.
module tb_mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   viol     = 0;

  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(WIDTH)) bus ();

  mdu_iter #(
    .WIDTH       (WIDTH),
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Protocol monitor: the hazard unit must never issue while the MDU is busy.
  always @(posedge clk) begin
    if (!reset && bus.start && bus.busy) viol <= viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start  = 1'b0;
    bus.op     = MDU_NOP;
    bus.a      = ZERO;
    bus.b      = ZERO;
    bus.cancel = 1'b0;
  endtask

  // Issue one multicycle op, measure busy length and done pulses.
  task automatic run_op(input logic [3:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, output int busy_cyc,
                        output logic done_first, output int done_cnt);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    idle_inputs();
    busy_cyc = 0;
    done_cnt = 0;
    while (bus.busy && busy_cyc < 200) begin
      busy_cyc++;
      if (bus.done) done_cnt++;
      tick();
    end
    done_first = bus.done;
    for (int i = 0; i < 3; i++) begin
      if (bus.done) done_cnt++;
      tick();
    end
  endtask

  task automatic mt_op(input logic [3:0] op, input logic [WIDTH-1:0] v, input logic cancel);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.a      = v;
    bus.cancel = cancel;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: got busy/done %b, expected 00", {bus.busy, bus.done});
    end
    checks++;
    if ({bus.hi, bus.lo} !== {ZERO, ZERO}) begin
      failures++;
      $display("FAIL reset_hilo: got %h_%h, expected 0_0", bus.hi, bus.lo);
    end
  endtask

  // Generic latency/done/result check for one op, inline per call site.
  task automatic test_op(input string name, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int exp_lat,
                         input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
    int   bc;
    int   dc;
    logic df;
    run_op(op, a, b, bc, df, dc);
    checks++;
    if (bc !== exp_lat) begin
      failures++;
      $display("FAIL %s_busy: got %0d cycles, expected %0d", name, bc, exp_lat);
    end
    checks++;
    if (!(df === 1'b1 && dc == 1)) begin
      failures++;
      $display("FAIL %s_done: got first=%b pulses=%0d, expected first=1 pulses=1", name, df, dc);
    end
    checks++;
    if ({bus.hi, bus.lo} !== {exp_hi, exp_lo}) begin
      failures++;
      $display("FAIL %s_result: got %h_%h, expected %h_%h", name, bus.hi, bus.lo,
               exp_hi, exp_lo);
    end
  endtask

  task automatic test_mult();
    test_op("mult", MDU_MULT, WIDTH'(-3), WIDTH'(7), MULT_CYCLES, ONES, WIDTH'(-21));
    test_op("multu", MDU_MULTU, ONES, WIDTH'(2), MULT_CYCLES, WIDTH'(1), WIDTH'(-2));
  endtask

  task automatic test_divide();
    test_op("divu", MDU_DIVU, WIDTH'(100), WIDTH'(7), DIV_CYCLES, WIDTH'(2), WIDTH'(14));
    test_op("div", MDU_DIV, WIDTH'(-7), WIDTH'(2), DIV_CYCLES, ONES, WIDTH'(-3));
  endtask

  task automatic test_div_corner();
    test_op("div_ovf", MDU_DIV, MIN, ONES, DIV_CYCLES, ZERO, MIN);
    test_op("divu_zero", MDU_DIVU, WIDTH'(5), ZERO, DIV_CYCLES, WIDTH'(5), ONES);
    test_op("div_zero", MDU_DIV, WIDTH'(-9), ZERO, DIV_CYCLES, WIDTH'(-9), ONES);
  endtask

  task automatic test_accumulate();
    mt_op(MDU_MTHI, WIDTH'(1), 1'b0);
    checks++;
    if ({bus.hi, bus.busy, bus.done} !== {WIDTH'(1), 2'b00}) begin
      failures++;
      $display("FAIL mthi: got hi=%h busy=%b done=%b, expected hi=1 busy=0 done=0",
               bus.hi, bus.busy, bus.done);
    end
    mt_op(MDU_MTLO, ONES, 1'b0);
    checks++;
    if ({bus.hi, bus.lo, bus.busy} !== {WIDTH'(1), ONES, 1'b0}) begin
      failures++;
      $display("FAIL mtlo: got %h_%h busy=%b, expected %h_%h busy=0",
               bus.hi, bus.lo, bus.busy, WIDTH'(1), ONES);
    end
    test_op("maddu", MDU_MADDU, WIDTH'(1), WIDTH'(1), MULT_CYCLES, WIDTH'(2), ZERO);
    test_op("madd", MDU_MADD, WIDTH'(-1), WIDTH'(3), MULT_CYCLES, WIDTH'(1), WIDTH'(-3));
    mt_op(MDU_MTHI, ZERO, 1'b0);
    mt_op(MDU_MTLO, ZERO, 1'b0);
    test_op("msub", MDU_MSUB, WIDTH'(1), WIDTH'(1), MULT_CYCLES, ONES, ONES);
  endtask

  task automatic test_cancel();
    int bad;
    // HI/LO hold all ones from the msub above.
    bus.start  = 1'b1;
    bus.op     = MDU_MULT;
    bus.a      = WIDTH'(2);
    bus.b      = WIDTH'(3);
    bus.cancel = 1'b1;
    tick();
    idle_inputs();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy || bus.done) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL cancel_start: got %0d busy/done cycles, expected 0", bad);
    end
    mt_op(MDU_MTHI, WIDTH'(5), 1'b1);
    checks++;
    if ({bus.hi, bus.lo} !== {ONES, ONES}) begin
      failures++;
      $display("FAIL cancel_hilo: got %h_%h, expected %h_%h", bus.hi, bus.lo, ONES, ONES);
    end
  endtask

  task automatic test_cancel_busy();
    int bc;
    bus.start = 1'b1;
    bus.op    = MDU_MULTU;
    bus.a     = WIDTH'(2);
    bus.b     = WIDTH'(3);
    tick();
    idle_inputs();
    bus.cancel = 1'b1;
    bc = 0;
    while (bus.busy && bc < 200) begin
      bc++;
      tick();
    end
    bus.cancel = 1'b0;
    checks++;
    if (bc != MULT_CYCLES) begin
      failures++;
      $display("FAIL cancel_busy_len: got %0d cycles, expected %0d", bc, MULT_CYCLES);
    end
    checks++;
    if ({bus.hi, bus.lo, bus.done} !== {ZERO, WIDTH'(6), 1'b1}) begin
      failures++;
      $display("FAIL cancel_busy_result: got %h_%h done=%b, expected 0_%h done=1",
               bus.hi, bus.lo, bus.done, WIDTH'(6));
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    int v0;
    int after;
    v0 = viol;
    bus.start = 1'b1;
    bus.op    = MDU_DIVU;
    bus.a     = WIDTH'(100);
    bus.b     = WIDTH'(7);
    tick();
    bc = bus.busy ? 1 : 0;
    // Illegal second issue while the divide is in flight.
    bus.op = MDU_MULT;
    bus.a  = WIDTH'(3);
    bus.b  = WIDTH'(3);
    tick();
    idle_inputs();
    while (bus.busy && bc < 200) begin
      bc++;
      tick();
    end
    checks++;
    if (bc != DIV_CYCLES) begin
      failures++;
      $display("FAIL busy_start_len: got %0d cycles, expected %0d", bc, DIV_CYCLES);
    end
    checks++;
    if ({bus.hi, bus.lo} !== {WIDTH'(2), WIDTH'(14)}) begin
      failures++;
      $display("FAIL busy_start_result: got %h_%h, expected 2_e", bus.hi, bus.lo);
    end
    after = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.busy) after++;
    end
    checks++;
    if (after != 0) begin
      failures++;
      $display("FAIL busy_start_ignored: got %0d busy cycles afterwards, expected 0", after);
    end
    checks++;
    if (viol - v0 != 1) begin
      failures++;
      $display("FAIL busy_start_assert: got %0d violations flagged, expected 1", viol - v0);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    k = (MULT_CYCLES >= 3) ? 3 : MULT_CYCLES;
    bus.start = 1'b1;
    bus.op    = MDU_MULTU;
    bus.a     = WIDTH'(4);
    bus.b     = WIDTH'(4);
    tick();
    idle_inputs();
    for (int i = 1; i < k; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, ZERO, ZERO}) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b done=%b %h_%h, expected busy=0 done=0 0_0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, ZERO, ZERO}) begin
      failures++;
      $display("FAIL reset_mid_stays: got busy=%b done=%b %h_%h, expected idle 0_0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divide();
    test_div_corner();
    test_accumulate();
    test_cancel();
    test_cancel_busy();
    test_back_to_back();
    test_reset_mid();
    test_op("post_reset", MDU_MULT, WIDTH'(-2), WIDTH'(-2), MULT_CYCLES, ZERO, WIDTH'(4));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
